// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan decoder.
// Holds the FSM state enum, the active-low segment table and the blank codes.
package seg_pkg;

    localparam int STABLE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Active-low glyphs for 0..F with bit 7 (dp) forced high; entry i is SEG_TABLE[i].
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] BLANK_CODE    = 8'hFF;
    localparam logic [7:0] BLANK_CODE_DP = 8'h7F;

endpackage

// File: rtl/seg_scan_decoder_seg7_decode.sv
// Combinational 7-segment pattern decoder: active-low {dp,g..a} in,
// hex nibble plus dp/blank/invalid flags out.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] nibble,
    output logic       dp,
    output logic       blank,
    output logic       invalid
);

    logic [7:0] masked_s;
    logic       hit_s;

    // Table lookup with dp masked off; unmatched patterns leave nibble at 0.
    always_comb begin
        masked_s = pattern | 8'h80;
        nibble   = 4'h0;
        hit_s    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nibble = (masked_s == SEG_TABLE[i]) ? 4'(i) : nibble;
            hit_s  = hit_s | (masked_s == SEG_TABLE[i]);
        end
        dp      = ~pattern[7];
        blank   = (pattern == BLANK_CODE) || (pattern == BLANK_CODE_DP);
        invalid = ~blank & ~hit_s;
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 8-digit 7-segment display bus, debounces each digit,
// and publishes a full-frame snapshot once all eight digits have been captured.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst,
    input  logic [7:0]  seg_data_0_pin,
    input  logic [7:0]  seg_data_1_pin,
    input  logic [7:0]  seg_cs_pin,
    output logic [31:0] digits_o,
    output logic [7:0]  dp_o,
    output logic [7:0]  blank_o,
    output logic        frame_valid_o,
    output logic        seg_err_o,
    output logic        cs_err_o
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

    logic [7:0]  cs_r;
    logic [7:0]  data0_r;
    logic [7:0]  data1_r;
    logic [7:0]  prev_cs_r;
    logic [7:0]  prev_data_r;
    logic [7:0]  count_r;
    state_t      state_r;
    logic [31:0] work_digits_r;
    logic [7:0]  work_dp_r;
    logic [7:0]  work_blank_r;
    logic [7:0]  mask_r;

    logic [7:0]  sel_data_s;
    logic [2:0]  sel_idx_s;
    logic [7:0]  count_inc_s;
    logic        cs_onehot_s;
    logic        cs_bad_s;
    logic        same_s;
    logic        capture_s;
    logic        mask_full_s;
    logic [3:0]  dec_nibble_s;
    logic        dec_dp_s;
    logic        dec_blank_s;
    logic        dec_invalid_s;

    seg7_decode u_dec (
        .pattern (sel_data_s),
        .nibble  (dec_nibble_s),
        .dp      (dec_dp_s),
        .blank   (dec_blank_s),
        .invalid (dec_invalid_s)
    );

    // Input sampling: every decision below works on these registered copies.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            cs_r    <= 8'h00;
            data0_r <= 8'hFF;
            data1_r <= 8'hFF;
        end else begin
            cs_r    <= seg_cs_pin;
            data0_r <= seg_data_0_pin;
            data1_r <= seg_data_1_pin;
        end
    end

    // Select decode, stability compare and capture condition.
    always_comb begin
        cs_onehot_s = (cs_r != 8'h00) && ((cs_r & (cs_r - 8'h01)) == 8'h00);
        cs_bad_s    = (cs_r != 8'h00) && !cs_onehot_s;
        sel_data_s  = (cs_r[3:0] != 4'h0) ? data0_r : data1_r;
        sel_idx_s   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            sel_idx_s = cs_r[i] ? 3'(i) : sel_idx_s;
        end
        same_s      = (cs_r == prev_cs_r) && (sel_data_s == prev_data_r);
        count_inc_s = (count_r < STABLE_LIM) ? (count_r + 8'd1) : count_r;
        capture_s   = (state_r == ST_TRACK) && cs_onehot_s && same_s &&
                      (count_inc_s >= STABLE_LIM);
        mask_full_s = (mask_r == 8'hFF);
    end

    // Debounce FSM: HOLD blocks re-capture until the digit or its pattern changes.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            count_r     <= 8'd0;
            prev_cs_r   <= 8'h00;
            prev_data_r <= 8'hFF;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_onehot_s) begin
                        state_r     <= ST_TRACK;
                        count_r     <= 8'd1;
                        prev_cs_r   <= cs_r;
                        prev_data_r <= sel_data_s;
                    end else begin
                        count_r <= 8'd0;
                    end
                end
                ST_TRACK: begin
                    if (!cs_onehot_s) begin
                        state_r <= ST_IDLE;
                        count_r <= 8'd0;
                    end else if (same_s) begin
                        count_r <= count_inc_s;
                        if (capture_s) begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        count_r     <= 8'd1;
                        prev_cs_r   <= cs_r;
                        prev_data_r <= sel_data_s;
                    end
                end
                ST_HOLD: begin
                    if (!cs_onehot_s) begin
                        state_r <= ST_IDLE;
                        count_r <= 8'd0;
                    end else if (!same_s) begin
                        state_r     <= ST_TRACK;
                        count_r     <= 8'd1;
                        prev_cs_r   <= cs_r;
                        prev_data_r <= sel_data_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= 8'd0;
                end
            endcase
        end
    end

    // Working frame, capture mask and snapshot; a capture coinciding with the
    // mask clear lands in the fresh mask, while the snapshot takes the old frame.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            work_digits_r <= 32'h0000_0000;
            work_dp_r     <= 8'h00;
            work_blank_r  <= 8'hFF;
            mask_r        <= 8'h00;
            digits_o      <= 32'h0000_0000;
            dp_o          <= 8'h00;
            blank_o       <= 8'hFF;
            frame_valid_o <= 1'b0;
        end else begin
            frame_valid_o <= mask_full_s;
            if (mask_full_s) begin
                digits_o <= work_digits_r;
                dp_o     <= work_dp_r;
                blank_o  <= work_blank_r;
            end
            if (capture_s) begin
                work_digits_r[{sel_idx_s, 2'b00} +: 4] <= dec_nibble_s;
                work_dp_r[sel_idx_s]                   <= dec_dp_s;
                work_blank_r[sel_idx_s]                <= dec_blank_s;
            end
            mask_r <= (mask_full_s ? 8'h00 : mask_r) | (capture_s ? cs_r : 8'h00);
        end
    end

    // Error pulses.
    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            seg_err_o <= 1'b0;
            cs_err_o  <= 1'b0;
        end else begin
            seg_err_o <= capture_s && dec_invalid_s;
            cs_err_o  <= cs_bad_s;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder with STABLE_CYC = 4.
module tb_seg_scan_decoder;
    import seg_pkg::*;

    logic        sys_clk_in = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  seg_data_0_pin = 8'hFF;
    logic [7:0]  seg_data_1_pin = 8'hFF;
    logic [7:0]  seg_cs_pin = 8'h00;
    logic [31:0] digits_o;
    logic [7:0]  dp_o;
    logic [7:0]  blank_o;
    logic        frame_valid_o;
    logic        seg_err_o;
    logic        cs_err_o;

    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int ce_cnt = 0;
    int fv_base;
    int se_base;
    int ce_base;

    logic [7:0] normal [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    seg_scan_decoder #(.STABLE_CYC(4)) dut (
        .sys_clk_in     (sys_clk_in),
        .sys_rst        (sys_rst),
        .seg_data_0_pin (seg_data_0_pin),
        .seg_data_1_pin (seg_data_1_pin),
        .seg_cs_pin     (seg_cs_pin),
        .digits_o       (digits_o),
        .dp_o           (dp_o),
        .blank_o        (blank_o),
        .frame_valid_o  (frame_valid_o),
        .seg_err_o      (seg_err_o),
        .cs_err_o       (cs_err_o)
    );

    always #5 sys_clk_in = ~sys_clk_in;

    // Count high cycles of each pulse output, sampled mid-cycle.
    always @(negedge sys_clk_in) begin
        fv_cnt = fv_cnt + int'(frame_valid_o);
        se_cnt = se_cnt + int'(seg_err_o);
        ce_cnt = ce_cnt + int'(cs_err_o);
    end

    task automatic drive(input logic [7:0] cs, input logic [7:0] d0,
                         input logic [7:0] d1, input int n);
        seg_cs_pin     = cs;
        seg_data_0_pin = d0;
        seg_data_1_pin = d1;
        repeat (n) @(negedge sys_clk_in);
    endtask

    task automatic show(input int idx, input logic [7:0] pat, input int n);
        logic [7:0] cs;
        cs = 8'h01 << idx;
        if (idx < 4) drive(cs, pat, 8'hFF, n);
        else         drive(cs, 8'hFF, pat, n);
    endtask

    // Full scan, 6 cycles per digit, with one digit optionally replaced.
    task automatic scan(input int odd_idx, input logic [7:0] odd_pat);
        for (int i = 0; i < 8; i++) begin
            show(i, (i == odd_idx) ? odd_pat : normal[i], 6);
        end
        drive(8'h00, 8'hFF, 8'hFF, 4);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk_in);
        #1;
        check("rst_digits", digits_o, 32'h0000_0000);
        check("rst_dp", {24'h0, dp_o}, 32'h0000_0000);
        check("rst_blank", {24'h0, blank_o}, 32'h0000_00FF);
        check("rst_fv", {31'h0, frame_valid_o}, 32'h0);
        check("rst_seg_err", {31'h0, seg_err_o}, 32'h0);
        check("rst_cs_err", {31'h0, cs_err_o}, 32'h0);
        sys_rst = 1'b0;

        // Plain 0..7 frame
        scan(-1, 8'h00);
        check("a_fv_count", fv_cnt, 1);
        check("a_digits", digits_o, 32'h7654_3210);
        check("a_dp", {24'h0, dp_o}, 32'h0000_0000);
        check("a_blank", {24'h0, blank_o}, 32'h0000_0000);
        check("a_seg_err", se_cnt, 0);
        check("a_cs_err", ce_cnt, 0);

        // Two select lines at once
        fv_base = fv_cnt;
        drive(8'h03, 8'hC0, 8'hFF, 2);
        #1;
        check("b_state_idle", {30'h0, dut.state_r}, {30'h0, ST_IDLE});
        drive(8'h00, 8'hFF, 8'hFF, 3);
        #1;
        check("b_cs_err_cycles", ce_cnt, 2);
        check("b_no_frame", fv_cnt, fv_base);

        // Digit 2: short dwell ignored, full dwell captured
        fv_base = fv_cnt;
        show(0, 8'hC0, 6);
        show(1, 8'hF9, 6);
        show(2, 8'h0E, 3);
        drive(8'h00, 8'hFF, 8'hFF, 2);
        for (int i = 3; i < 8; i++) show(i, normal[i], 6);
        drive(8'h00, 8'hFF, 8'hFF, 4);
        #1;
        check("c_short_dwell_no_frame", fv_cnt, fv_base);
        show(2, 8'h0E, 4);
        drive(8'h00, 8'hFF, 8'hFF, 4);
        #1;
        check("c_fv_count", fv_cnt, fv_base + 1);
        check("c_digits", digits_o, 32'h7654_3F10);
        check("c_dp", {24'h0, dp_o}, 32'h0000_0004);
        check("c_blank", {24'h0, blank_o}, 32'h0000_0000);

        // Digit 5 blank
        fv_base = fv_cnt;
        se_base = se_cnt;
        scan(5, 8'hFF);
        check("d_fv_count", fv_cnt, fv_base + 1);
        check("d_digits", digits_o, 32'h7604_3210);
        check("d_blank", {24'h0, blank_o}, 32'h0000_0020);
        check("d_dp", {24'h0, dp_o}, 32'h0000_0000);
        check("d_no_seg_err", se_cnt, se_base);

        // Digit 1 undecodable
        fv_base = fv_cnt;
        se_base = se_cnt;
        ce_base = ce_cnt;
        scan(1, 8'hAA);
        check("e_seg_err_once", se_cnt, se_base + 1);
        check("e_fv_count", fv_cnt, fv_base + 1);
        check("e_digits", digits_o, 32'h7654_3200);
        check("e_blank", {24'h0, blank_o}, 32'h0000_0000);
        check("e_no_cs_err", ce_cnt, ce_base);

        // Reset mid-frame, then partial and full scans of 8
        for (int i = 0; i < 5; i++) show(i, 8'h80, 6);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk_in);
        #1;
        check("f_rst_digits", digits_o, 32'h0000_0000);
        check("f_rst_blank", {24'h0, blank_o}, 32'h0000_00FF);
        sys_rst = 1'b0;
        fv_base = fv_cnt;
        for (int i = 5; i < 8; i++) show(i, 8'h80, 6);
        drive(8'h00, 8'hFF, 8'hFF, 4);
        #1;
        check("f_partial_no_frame", fv_cnt, fv_base);
        for (int i = 0; i < 8; i++) show(i, 8'h80, 6);
        drive(8'h00, 8'hFF, 8'hFF, 4);
        #1;
        check("f_single_frame", fv_cnt, fv_base + 1);
        check("f_digits", digits_o, 32'h8888_8888);
        check("f_dp", {24'h0, dp_o}, 32'h0000_0000);
        check("f_blank", {24'h0, blank_o}, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 SHALL have port sys_clk_in, input, 1 bit: the single clock; all state is in this domain.
REQ-003 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port seg_data_0_pin, input, 8 bits: segments for digit group 0 (digits 0-3), active-low, {dp,g,f,e,d,c,b,a}.
REQ-005 SHALL have port seg_data_1_pin, input, 8 bits: segments for digit group 1 (digits 4-7), same encoding.
REQ-006 SHALL have port seg_cs_pin, input, 8 bits: digit select, active-high, one-hot; bit i selects digit i.
REQ-007 SHALL have port digits_o, output, 32 bits: frame snapshot; nibble i holds the hex value of digit i.
REQ-008 SHALL have port dp_o, output, 8 bits: frame snapshot of the decimal points, 1 = lit.
REQ-009 SHALL have port blank_o, output, 8 bits: frame snapshot, 1 = digit was all-off (8'hFF or 8'h7F).
REQ-010 SHALL have port frame_valid_o, output, 1 bit: one-cycle pulse when the snapshot updates.
REQ-011 SHALL have port seg_err_o, output, 1 bit: one-cycle pulse when a stable pattern is not decodable.
REQ-012 SHALL have port cs_err_o, output, 1 bit: one-cycle pulse when seg_cs_pin is nonzero and not one-hot.

Function
REQ-013 SHALL register all three input buses once; all decisions use the registered copies, which adds 1 cycle of latency.
REQ-014 SHALL select group-0 data when the one-hot bit is in cs[3:0] and group-1 data when it is in cs[7:4].
REQ-015 SHALL decode segment bits [6:0] with this table, 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (bit 7 masked to 1); bit 7 low means dp lit.
REQ-016 SHALL implement states IDLE, TRACK and HOLD.
REQ-017 IDLE: cs zero or not one-hot; moves to TRACK with count=1 when cs is one-hot.
REQ-018 TRACK: increments count each cycle in which cs and the selected data equal the previous sample; any difference restarts count=1 with the new values; invalid or zero cs returns to IDLE.
REQ-019 When count reaches STABLE_CYC, SHALL capture the digit (nibble, dp, blank) into a working register, set bit i of the capture mask, and move to HOLD.
REQ-020 HOLD: stays until cs or the selected data changes, then goes to TRACK (count=1) or IDLE; the same pattern is never captured twice.
REQ-021 An undecodable, non-blank stable pattern SHALL pulse seg_err_o, store nibble 0 and blank=0, and still set the mask bit.
REQ-022 cs_err_o SHALL pulse on every cycle the registered cs is nonzero and not one-hot.
REQ-023 A recapture of a digit already in the mask SHALL overwrite the working register and leave the mask unchanged.
REQ-024 When the mask becomes 8'hFF, SHALL, on the next edge, copy the working register to digits_o/dp_o/blank_o, pulse frame_valid_o, and clear the mask.
REQ-025 The copy SHALL include the digit that completed the mask.
REQ-026 A capture arriving in the same cycle as the mask clear SHALL set its bit in the new, cleared mask.
REQ-027 The counter SHALL saturate at STABLE_CYC and never wrap.

Reset
REQ-028 Reset SHALL set: state IDLE, count 0, mask 0, input registers to 0 (cs) and 8'hFF (data), digits_o 0, dp_o 0, blank_o 8'hFF, and all pulses 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first frame_valid_o after release requires all 8 digits to be captured afresh.

Structure
REQ-030 Package seg_pkg SHALL hold the state enum, the 16-entry segment table, the blank codes, and the STABLE_CYC default.
REQ-031 Sub-module seg7_decode SHALL be combinational: 8-bit pattern in; nibble, dp, blank and invalid flags out.

Verification
REQ-032 Scan 8 digits, each held 6 cycles, with data C0,F9,A4,B0,99,92,82,F8 -> one frame_valid_o; digits_o=32'h76543210, dp_o=0, blank_o=0.
REQ-033 Digit 2 shows 8'h0E (F with dp), held 3 cycles then 4 cycles, STABLE_CYC=4 -> captured only on the second dwell; nibble 2=F, dp_o[2]=1.
REQ-034 Digit 5 shows 8'hFF in an otherwise valid frame -> blank_o=8'h20, nibble 5=0, no seg_err_o.
REQ-035 cs=8'h03 for 2 cycles -> cs_err_o high for 2 cycles, no capture, state IDLE.
REQ-036 Digit 1 shows 8'hAA, stable -> seg_err_o pulses once; the frame still completes once all 8 digits are captured.
REQ-037 Reset asserted after 5 digits, then a full scan of 8'h80 -> a single frame, digits_o=32'h88888888.
